cnt_pwm_gen: RTL and testbench
==============================

Name: cnt_pwm_gen

Overview:
Downstream consumer of the free-running 8-bit counter (`counter`, output `cnt`). Turns the counter value into a period-aligned PWM waveform whose duty is loaded through a valid/ready handshake. New duty values go into a shadow register and take effect only at counter wrap, so no partial or glitched periods are produced. Runs on the same 50 MHz domain as the counter; one period is 256 clocks (5120 ns).

Parameters:
- WIDTH, 8, width of counter input and duty value
- CNT_MAX, 2**WIDTH-1, last counter value before wrap
- DEAD_CYC, 4, dead-time in clocks; used only with PWM_DEADTIME_EN

Ports:
- clk       in   1      system clock, 50 MHz
- rst_n     in   1      asynchronous, active-low reset
- cnt_i     in   WIDTH  counter value from `counter.cnt`
- en_i      in   1      run request
- duty_i    in   WIDTH  new duty, in clocks high per period
- duty_vld  in   1      duty_i valid
- duty_rdy  out  1      shadow slot free
- pwm_o     out  1      PWM output, registered
- pwm_n_o   out  1      complementary output
- wrap_o    out  1      one-clock pulse per period boundary
- busy_o    out  1      high when state != IDLE

Behaviour:
- Reset values (async on rst_n low): all outputs 0 except duty_rdy=1. Also: state=IDLE, duty_act=0, duty_pend=0, pend_flag=0, cnt_q=0.
- cnt_q registers cnt_i every clock.
- Wrap event: wrap = (cnt_q==CNT_MAX) && (cnt_i==0). Combinational; wrap_o is its registered copy, so the pulse is high in the clock after cnt_i==0 is sampled.
- Handshake: transfer occurs when duty_vld && duty_rdy. duty_i is captured into duty_pend and pend_flag is set.
  - duty_rdy = !pend_flag.
  - A 1-deep slot: while pending, a second value is stalled (no overwrite).
  - A transfer in the same cycle as wrap is NOT applied at that wrap; it becomes pending for the next one.
- Apply: on wrap with pend_flag=1, duty_act <= duty_pend and pend_flag clears. duty_rdy rises the next clock.
  - Apply happens in every state, including IDLE, so software can preload.
- FSM (encoding in package):
  - IDLE: pwm_o=0. en_i=1 -> ARM.
  - ARM: pwm_o=0, waiting for period alignment. wrap -> RUN. en_i=0 -> IDLE.
  - RUN: normal operation. en_i=0 -> DRAIN.
  - DRAIN: finishes the current period. wrap -> IDLE. en_i=1 -> RUN.
- PWM: pwm_o <= (state is RUN or DRAIN, or entering RUN this clock) && (cnt_i < duty_eff).
  - duty_eff is the value being applied on a wrap clock; otherwise duty_act.
  - Latency: one clock from cnt_i.
  - duty=0 -> constant low. duty=CNT_MAX -> high 255 of 256 clocks (100% not reachable by design).
  - Comparison is unsigned, WIDTH bits, with no wrap arithmetic.
- Counter reset mid-run (cnt_i jumps to 0 without cnt_q==CNT_MAX): not a wrap. No pending apply, no wrap_o, PWM continues on the compare.
- busy_o = (state != IDLE).
- rst_n low mid-operation: immediate return to reset values and the pending duty is discarded.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- Defined:
  - pwm_o and pwm_n_o pass through sub-module cnt_pwm_deadtime.
  - After every edge of the raw PWM, both outputs are held low for DEAD_CYC clocks, then the newly active side rises.
  - A pulse shorter than DEAD_CYC is swallowed on that side.
  - Adds no latency to falling edges; rising edges are delayed by DEAD_CYC.
- Undefined:
  - pwm_n_o = !pwm_o while state is RUN/DRAIN, else 0.
  - DEAD_CYC is ignored.

Decomposition:
- Package cnt_pwm_pkg holds:
  - state typedef (IDLE, ARM, RUN, DRAIN; 2-bit)
  - WIDTH default
  - CNT_MAX function
  - DEAD_CYC default
- Sub-module cnt_pwm_deadtime (clk, rst_n, raw_i, p_o, n_o, DEAD_CYC parameter), instantiated only under PWM_DEADTIME_EN.

Test Plan:
- Reset/preload: rst_n low 200 ns, drive counter, duty 64 accepted in IDLE, en_i=1 -> pwm_o stays 0 until first wrap_o, then high exactly 64 clocks per 256 for 3 periods.
- Shadow update: in RUN with duty 64, load 192 at cnt=100 -> current period stays 64 high; next period is 192 high. duty_rdy low from load until the clock after wrap.
- Stall/same-cycle: hold duty_vld with 10 then 20 while pending -> 20 not accepted until duty_rdy rises. A transfer coincident with wrap applies one period later.
- Extremes: duty 0 -> pwm_o never high. Duty 255 -> pwm_o low only at cnt=255. wrap_o period = 256 clocks (5120 ns).
- Drain/abort: en_i=0 at cnt=50 -> period completes, busy_o falls after wrap. en_i re-asserted at cnt=80 -> no interruption. Counter rst_n pulse mid-run -> no wrap_o, no apply.
- PWM_DEADTIME_EN, DEAD_CYC=4, duty 64:
  - pwm_o and pwm_n_o are never high together.
  - Both are low for 4 clocks around each transition.
  - pwm_o high 60 clocks per period.

Source files
------------

// File: rtl/cnt_pwm_pkg.sv
// Shared state type, defaults and helper for the counter-driven PWM generator.
`timescale 1ns/1ps
package cnt_pwm_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_DEAD_CYC = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARM   = 2'b01,
    RUN   = 2'b10,
    DRAIN = 2'b11
  } pwm_state_e;

  // Last counter value before a free-running WIDTH-bit counter wraps.
  function automatic int unsigned cnt_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/cnt_pwm_deadtime.sv
// Dead-time inserter: splits a raw PWM into non-overlapping high/low drives.
`timescale 1ns/1ps
module cnt_pwm_deadtime
  import cnt_pwm_pkg::*;
#(
  parameter int unsigned DEAD_CYC = DEF_DEAD_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic p_o,
  output logic n_o
);

  localparam int unsigned    CW   = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [CW-1:0]  LOAD = CW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

  logic          raw_q;
  logic [CW-1:0] dt_cnt;
  logic          edge_now;
  logic          hold;

  assign edge_now = raw_i ^ raw_q;
  // Both sides stay low on the edge clock and the DEAD_CYC-1 clocks after it.
  assign hold     = (DEAD_CYC != 0) && (edge_now || (dt_cnt != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q  <= 1'b0;
      dt_cnt <= '0;
    end else begin
      raw_q <= raw_i;
      if (edge_now) begin
        dt_cnt <= LOAD;
      end else if (dt_cnt != '0) begin
        dt_cnt <= dt_cnt - CW'(1);
      end
    end
  end

  // Falling sides follow raw_i directly, so only rising edges see the delay.
  assign p_o = raw_i && !hold;
  assign n_o = !raw_i && !hold;

endmodule

// File: rtl/cnt_pwm_gen.sv
// Period-aligned PWM driven by an external free-running counter, with shadowed duty.
// Build option PWM_DEADTIME_EN routes both outputs through cnt_pwm_deadtime.
`timescale 1ns/1ps
module cnt_pwm_gen
  import cnt_pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CNT_MAX  = cnt_max(WIDTH),
  parameter int unsigned DEAD_CYC = DEF_DEAD_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic             duty_vld,
  output logic             duty_rdy,
  output logic             pwm_o,
  output logic             pwm_n_o,
  output logic             wrap_o,
  output logic             busy_o
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(CNT_MAX);

  if (DEAD_CYC > 1024) begin : g_dead_cyc_chk
    $error("cnt_pwm_gen: DEAD_CYC out of range");
  end

  pwm_state_e       state;
  pwm_state_e       state_nxt;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] duty_act;
  logic [WIDTH-1:0] duty_pend;
  logic [WIDTH-1:0] duty_eff;
  logic             pend_flag;
  logic             wrap;
  logic             apply;
  logic             xfer;
  logic             active_nxt;
  logic             below;
  logic             pwm_raw;

  // A counter reset lands on 0 without passing CNT_LAST, so it is not a wrap.
  assign wrap     = (cnt_q == CNT_LAST) && (cnt_i == '0);
  assign apply    = wrap && pend_flag;
  assign duty_rdy = !pend_flag;
  assign xfer     = duty_vld && duty_rdy;
  assign duty_eff = apply ? duty_pend : duty_act;
  assign below    = cnt_i < duty_eff;
  assign busy_o   = (state != IDLE);

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    state_nxt  = state;
    active_nxt = 1'b0;
    case (state)
      IDLE:    if (en_i) state_nxt = ARM;
      ARM:     if (!en_i) state_nxt = IDLE;
               else if (wrap) state_nxt = RUN;
      RUN:     if (!en_i) state_nxt = DRAIN;
      DRAIN:   if (en_i) state_nxt = RUN;
               else if (wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Gating on the next state starts output on the aligning wrap and stops it
    // exactly at the draining wrap, so no sliver of a new period escapes.
    active_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments, so every register samples pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      cnt_q     <= '0;
      wrap_o    <= 1'b0;
      duty_act  <= '0;
      duty_pend <= '0;
      pend_flag <= 1'b0;
      pwm_raw   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt_q   <= cnt_i;
      wrap_o  <= wrap;
      pwm_raw <= active_nxt && below;
      // A transfer can never coincide with an apply: the slot is full then.
      if (apply) begin
        duty_act  <= duty_pend;
        pend_flag <= 1'b0;
      end else if (xfer) begin
        duty_pend <= duty_i;
        pend_flag <= 1'b1;
      end
    end
  end

`ifdef PWM_DEADTIME_EN
  logic dt_p;
  logic dt_n;

  cnt_pwm_deadtime #(
    .DEAD_CYC (DEAD_CYC)
  ) u_deadtime (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (pwm_raw),
    .p_o   (dt_p),
    .n_o   (dt_n)
  );

  assign pwm_o   = dt_p;
  assign pwm_n_o = dt_n && ((state == RUN) || (state == DRAIN));
`else
  logic pwm_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_n_q <= 1'b0;
    end else begin
      pwm_n_q <= active_nxt && !below;
    end
  end

  assign pwm_o   = pwm_raw;
  assign pwm_n_o = pwm_n_q;
`endif

endmodule

// File: tb/tb_cnt_pwm_gen.sv
// Bench for cnt_pwm_gen: hand vectors, directed period sequences, random run vs model.
`timescale 1ns/1ps
module tb_cnt_pwm_gen;

  localparam int W  = 8;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] cnt_i;
  logic         en_i;
  logic [W-1:0] duty_i;
  logic         duty_vld;
  logic         duty_rdy;
  logic         pwm_o;
  logic         pwm_n_o;
  logic         wrap_o;
  logic         busy_o;

  always #10 clk = ~clk;

  cnt_pwm_gen #(
    .WIDTH    (W),
    .CNT_MAX  (255),
    .DEAD_CYC (DC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt_i    (cnt_i),
    .en_i     (en_i),
    .duty_i   (duty_i),
    .duty_vld (duty_vld),
    .duty_rdy (duty_rdy),
    .pwm_o    (pwm_o),
    .pwm_n_o  (pwm_n_o),
    .wrap_o   (wrap_o),
    .busy_o   (busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending slot as a queue, run status as plain flags.
  int  m_prev_cnt;
  int  m_act;
  int  m_pend_q[$];
  bit  m_armed, m_active, m_drain, m_accepted;
  bit  raw_hist[DC+1];
  bit  e_pwm, e_pwm_n, e_wrap, e_busy, e_rdy;

  task automatic model_reset();
    m_prev_cnt = 0;
    m_act      = 0;
    m_pend_q.delete();
    m_armed    = 0;
    m_active   = 0;
    m_drain    = 0;
    m_accepted = 0;
    for (int k = 0; k <= DC; k++) raw_hist[k] = 0;
    e_pwm = 0; e_pwm_n = 0; e_wrap = 0; e_busy = 0; e_rdy = 1;
  endtask

  task automatic model_step();
    bit wrap, apply, hi, n_armed, n_active, n_drain, all1, all0;
    int c, eff;
    c      = int'(cnt_i);
    wrap   = (m_prev_cnt == 255) && (c == 0);
    apply  = wrap && (m_pend_q.size() != 0);
    eff    = apply ? m_pend_q[0] : m_act;
    m_accepted = duty_vld && (m_pend_q.size() == 0);
    n_armed = m_armed; n_active = m_active; n_drain = m_drain;
    if (!m_armed && !m_active) n_armed = en_i;
    else if (m_armed) begin
      if (!en_i) n_armed = 0;
      else if (wrap) begin n_armed = 0; n_active = 1; end
    end else if (!m_drain) n_drain = !en_i;
    else if (en_i) n_drain = 0;
    else if (wrap) begin n_active = 0; n_drain = 0; end
    hi = n_active && (c < eff);
`ifdef PWM_DEADTIME_EN
    for (int k = DC; k > 0; k--) raw_hist[k] = raw_hist[k-1];
    raw_hist[0] = hi;
    all1 = 1; all0 = 1;
    for (int k = 0; k <= DC; k++) begin
      all1 &= raw_hist[k];
      all0 &= !raw_hist[k];
    end
    e_pwm   = all1;
    e_pwm_n = n_active && all0;
`else
    all1 = 0; all0 = 0;
    e_pwm   = hi;
    e_pwm_n = n_active && !(c < eff);
`endif
    if (apply) begin
      m_act = m_pend_q.pop_front();
    end else if (m_accepted) begin
      m_pend_q.push_back(int'(duty_i));
    end
    e_wrap   = wrap;
    e_busy   = n_armed || n_active;
    e_rdy    = (m_pend_q.size() == 0);
    m_armed  = n_armed; m_active = n_active; m_drain = n_drain;
    m_prev_cnt = c;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("pwm_o", pwm_o, e_pwm);
    check("pwm_n_o", pwm_n_o, e_pwm_n);
    check("wrap_o", wrap_o, e_wrap);
    check("busy_o", busy_o, e_busy);
    check("duty_rdy", duty_rdy, e_rdy);
`ifdef PWM_DEADTIME_EN
    check("overlap", pwm_o && pwm_n_o, 0);
`endif
  endtask

  // Stimulus state: emulated counter, run request and a duty producer.
  logic [W-1:0] cnt_val;
  logic         en_val;
  logic         req;
  logic [W-1:0] req_val;
  int           hi_q[$], len_q[$];
  int           hi_acc, len_acc, wrap_total;
  bit           track;

  task automatic req_on(input logic [W-1:0] d);
    req = 1; req_val = d;
  endtask

  task automatic clear_meas();
    hi_q.delete(); len_q.delete();
    hi_acc = 0; len_acc = 0; track = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cnt_i = cnt_val; en_i = en_val; duty_vld = req; duty_i = req_val;
      step();
      if (m_accepted) req = 0;
      cnt_val = cnt_val + 8'd1;
      if (wrap_o) begin
        if (track) begin
          hi_q.push_back(hi_acc);
          len_q.push_back(len_acc);
        end
        track = 1; hi_acc = 0; len_acc = 0;
        wrap_total++;
      end
      hi_acc += int'(pwm_o);
      len_acc++;
    end
  endtask

  task automatic run_to(input logic [W-1:0] target);
    while (cnt_val != target) run(1);
  endtask

  function automatic int exp_hi(input int d);
`ifdef PWM_DEADTIME_EN
    return (d > DC) ? d - DC : 0;
`else
    return d;
`endif
  endfunction

  task automatic check_period(input string name, input int idx, input int duty);
    if (idx < hi_q.size()) begin
      check({name, "_high"}, hi_q[idx], exp_hi(duty));
      check({name, "_len"}, len_q[idx], 256);
    end else begin
      check({name, "_missing"}, hi_q.size(), idx + 1);
    end
  endtask

  task automatic do_reset(input int cycles);
    #4 rst_n = 1'b0;
    #1;
    model_reset();
    req = 0; en_val = 0;
    check("rst_pwm_o", pwm_o, 0);
    check("rst_pwm_n_o", pwm_n_o, 0);
    check("rst_wrap_o", wrap_o, 0);
    check("rst_busy_o", busy_o, 0);
    check("rst_duty_rdy", duty_rdy, 1);
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic         en;
    logic [W-1:0] cnt;
    logic         vld;
    logic [W-1:0] duty;
    logic         pwm;
    logic         pwm_n;
    logic         wrap;
    logic         busy;
    logic         rdy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    rst_n = 1'b0; cnt_i = '0; en_i = 0; duty_i = '0; duty_vld = 0;
    cnt_val = '0; en_val = 0; req = 0; req_val = '0; wrap_total = 0;
    clear_meas();
    do_reset(10);

    // en  cnt  vld duty | pwm pwm_n wrap busy rdy
    tbl[0] = '{0, 8'd254, 1, 8'd3, 0, 0, 0, 0, 0};  // preload in IDLE
    tbl[1] = '{1, 8'd255, 0, 8'd0, 0, 0, 0, 1, 0};  // ARM
    tbl[2] = '{1, 8'd0,   0, 8'd0, 1, 0, 1, 1, 1};  // wrap: apply 3, enter RUN
    tbl[3] = '{1, 8'd1,   0, 8'd0, 1, 0, 0, 1, 1};
    tbl[4] = '{1, 8'd3,   0, 8'd0, 0, 1, 0, 1, 1};  // cnt == duty -> low
    tbl[5] = '{1, 8'd2,   1, 8'd9, 1, 0, 0, 1, 0};  // load 9
    tbl[6] = '{1, 8'd0,   0, 8'd0, 1, 0, 0, 1, 0};  // jump to 0: no wrap, no apply
    tbl[7] = '{0, 8'd255, 0, 8'd0, 0, 1, 0, 1, 0};  // DRAIN
    tbl[8] = '{0, 8'd0,   0, 8'd0, 0, 0, 1, 0, 1};  // wrap: apply 9, back to IDLE
    for (int i = 0; i < 9; i++) begin
      en_i = tbl[i].en; cnt_i = tbl[i].cnt; duty_vld = tbl[i].vld; duty_i = tbl[i].duty;
      @(posedge clk);
      #1;
`ifndef PWM_DEADTIME_EN
      check($sformatf("vec%0d_pwm", i), pwm_o, tbl[i].pwm);
      check($sformatf("vec%0d_pwm_n", i), pwm_n_o, tbl[i].pwm_n);
`endif
      check($sformatf("vec%0d_wrap", i), wrap_o, tbl[i].wrap);
      check($sformatf("vec%0d_busy", i), busy_o, tbl[i].busy);
      check($sformatf("vec%0d_rdy", i), duty_rdy, tbl[i].rdy);
    end
    duty_vld = 0;

    // Preload 64 in IDLE, enable, stay low until the first wrap, then 3 periods.
    do_reset(10);
    cnt_val = 8'd10;
    req_on(8'd64);
    run(4);
    check("preload_rdy", duty_rdy, 0);
    en_val = 1;
    clear_meas();
    run_to(8'd0);
    check("arm_low", hi_acc, 0);
    check("arm_busy", busy_o, 1);
    clear_meas();
    run(3 * 256 + 1);
    for (int p = 0; p < 3; p++) check_period($sformatf("preload_p%0d", p), p, 64);

    // Shadow update mid-period.
    run_to(8'd0);
    clear_meas();
    for (int i = 0; i < 2 * 256 + 1; i++) begin
      if (i == 100) req_on(8'd192);
      run(1);
      if (i == 100) check("shadow_rdy_load", duty_rdy, 0);
      if (i == 255) check("shadow_rdy_pre", duty_rdy, 0);
      if (i == 256) check("shadow_rdy_post", duty_rdy, 1);
    end
    check_period("shadow_cur", 0, 64);
    check_period("shadow_next", 1, 192);

    // Stall while pending, then a transfer coincident with wrap.
    run_to(8'd20);
    req_on(8'd10);
    run(1);
    req_on(8'd20);
    run_to(8'd0);
    check("stall_rdy", duty_rdy, 0);
    clear_meas();
    run(1);
    check("stall_rdy_rise", duty_rdy, 1);
    run(1);
    check("stall_accept", duty_rdy, 0);
    req_on(8'd30);
    run_to(8'd0); run(1); run(1);
    run_to(8'd0); run(1);
    check("slot_empty", duty_rdy, 1);
    run_to(8'd0);
    req_on(8'd40);
    run(1);
    check("coincident_rdy", duty_rdy, 0);
    run_to(8'd0); run(1);
    run_to(8'd0); run(1);
    check_period("stall_p0", 0, 10);
    check_period("stall_p1", 1, 20);
    check_period("stall_p2", 2, 30);
    check_period("coinc_p3", 3, 30);
    check_period("coinc_p4", 4, 40);

    // Extremes: duty 0 and duty CNT_MAX.
    req_on(8'd0);
    run_to(8'd0);
    clear_meas();
    run(1);
    req_on(8'd255);
    run_to(8'd0); run(1);
    run_to(8'd0); run(1);
    check_period("duty0", 0, 0);
    check_period("duty255", 1, 255);

    // Drain: disable mid-period, period completes, busy drops after the wrap.
    run_to(8'd0);
    clear_meas();
    run(1);
    run_to(8'd50);
    en_val = 0;
    run_to(8'd0);
    check("drain_busy_pre", busy_o, 1);
    run(1);
    check("drain_busy_post", busy_o, 0);
    check_period("drain", 0, 255);

    // Disable then re-enable within a period: no interruption.
    en_val = 1;
    run_to(8'd0);
    clear_meas();
    run(1);
    run_to(8'd50);
    en_val = 0;
    run_to(8'd80);
    en_val = 1;
    run_to(8'd0);
    run(1);
    check("reen_busy", busy_o, 1);
    check_period("reen", 0, 255);

    // Counter reset mid-run: not a wrap, pending value stays pending.
    req_on(8'd100);
    run(1);
    run_to(8'd120);
    cnt_val = 8'd0;
    begin
      int w0;
      w0 = wrap_total;
      run(20);
      check("cntrst_no_wrap", wrap_total - w0, 0);
      check("cntrst_pending", duty_rdy, 0);
    end
    run_to(8'd0);
    run(1);
    check("cntrst_apply", duty_rdy, 1);

    // Async reset mid-operation discards the pending duty.
    run_to(8'd30);
    req_on(8'd77);
    run(1);
    check("midrst_loaded", duty_rdy, 0);
    do_reset(10);
    run(2);
    check("midrst_rdy", duty_rdy, 1);
    check("midrst_busy", busy_o, 0);

    // Random traffic against the model.
    en_val = 1;
    clear_meas();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(299) == 0) en_val = !en_val;
      if (!req && $urandom_range(29) == 0) begin
        case ($urandom_range(3))
          0:       req_val = 8'd0;
          1:       req_val = 8'd255;
          default: req_val = 8'($urandom_range(255));
        endcase
        req = 1;
      end
      if ($urandom_range(1499) == 0) cnt_val = 8'($urandom_range(255));
      run(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
